// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences one load or shift/rotate command onto a 4-bit universal shift register.
// Latency: LOAD completes (done) 2 cycles after the start edge; shift by N in N+1 cycles; N=0 in 1 cycle.
// Backpressure: none; start is only sampled in IDLE, and starts seen in LOAD/SHIFT/DONE are ignored.
//
// Ports:
//   clk, clear        clock (rising edge), asynchronous active-low reset shared with the register
//   start/op/amount/data_in   command strobe, op code, shift count, parallel load value
//   sr_q              register parallel output, used for rotate / arithmetic serial feedback
//   sr_s/sr_msb/sr_lsb/sr_i   register mode, top/bottom serial inputs, parallel load data
//   busy/done/err     in LOAD/SHIFT, one-cycle completion pulse, one-cycle illegal-op pulse
//   abort             only with SHIFT_SEQ_ABORT_EN defined: ends a SHIFT early without shifting
//
// Build option: define SHIFT_SEQ_ABORT_EN to add the abort input.

module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [CNT_W-1:0] amount,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] sr_q,
`ifdef SHIFT_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic [1:0]       sr_s,
   output logic             sr_msb,
   output logic             sr_lsb,
   output logic [WIDTH-1:0] sr_i,
   output logic             busy,
   output logic             done,
   output logic             err
);

   // Command codes
   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_SHR  = 3'd1;
   localparam logic [2:0] OP_SHL  = 3'd2;
   localparam logic [2:0] OP_ROR  = 3'd3;
   localparam logic [2:0] OP_ROL  = 3'd4;
   localparam logic [2:0] OP_ASR  = 3'd5;

   // Register mode encodings
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;  // toward bit0, sr_msb enters the top
   localparam logic [1:0] MODE_UP   = 2'b10;  // toward bit WIDTH-1, sr_lsb enters bit0
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Latched command: op code plus the parallel data that sr_i presents
   typedef struct packed {
      logic [2:0]       op;
      logic [WIDTH-1:0] dat;
   } cmd_t;

   state_t           state_q;
   state_t           state_d;
   cmd_t             cmd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   logic             accept;
   logic             op_legal;
   logic             abort_hit;
   logic             shift_up;
   logic             last_shift;

   // Only the end bits of the register feed back into the serial inputs.
   logic             unused_sr_mid;
   assign unused_sr_mid = ^sr_q[WIDTH-2:1];

   assign accept     = (state_q == ST_IDLE) && start;
   assign op_legal   = (op <= OP_ASR);
   assign shift_up   = (cmd_q.op == OP_SHL) || (cmd_q.op == OP_ROL);
   assign last_shift = (cnt_q <= CNT_W'(1));

`ifdef SHIFT_SEQ_ABORT_EN
   assign abort_hit = (state_q == ST_SHIFT) && abort;
`else
   assign abort_hit = 1'b0;
`endif

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (op == OP_LOAD) begin
                  state_d = ST_LOAD;
               end else if (!op_legal) begin
                  state_d = ST_IDLE;
               end else if (amount != '0) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_LOAD: begin
            state_d = ST_DONE;
         end
         ST_SHIFT: begin
            // An abort skips the remaining shifts, including the one this cycle.
            if (abort_hit || last_shift) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Command latch, shift counter and error pulse
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         cmd_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         // err lasts exactly the cycle after the rejected start edge
         err_q <= accept && !op_legal;
         if (accept) begin
            cmd_q.op  <= op;
            cmd_q.dat <= data_in;
            cnt_q     <= amount;
         end else if (state_q == ST_SHIFT) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Output decode from registered state
   // ------------------------------------------------------------------
   always_comb begin
      sr_s   = MODE_HOLD;
      sr_msb = 1'b0;
      sr_lsb = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (state_q)
         ST_LOAD: begin
            sr_s = MODE_LOAD;
            busy = 1'b1;
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (!abort_hit) begin
               sr_s = shift_up ? MODE_UP : MODE_DOWN;
               // Feedback is taken live from sr_q so every step sees the
               // value produced by the previous step.
               case (cmd_q.op)
                  OP_ROR:  sr_msb = sr_q[0];
                  OP_ASR:  sr_msb = sr_q[WIDTH-1];
                  OP_ROL:  sr_lsb = sr_q[WIDTH-1];
                  default: begin
                     sr_msb = 1'b0;
                     sr_lsb = 1'b0;
                  end
               endcase
            end
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            sr_s = MODE_HOLD;
         end
      endcase
   end

   assign sr_i = cmd_q.dat;
   assign err  = err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: drives directed commands into shift_seq_ctrl wired to a register model.
// Each accepted command expands into an expected per-cycle timeline computed from shift arithmetic.
// A single negedge process compares every DUT output and the register value against that timeline.

module tb_shift_seq_ctrl;

   localparam int WIDTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             clear;
   logic             start;
   logic [2:0]       op;
   logic [CNT_W-1:0] amount;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] sr_q;
   logic [1:0]       sr_s;
   logic             sr_msb;
   logic             sr_lsb;
   logic [WIDTH-1:0] sr_i;
   logic             busy;
   logic             done;
   logic             err;
`ifdef SHIFT_SEQ_ABORT_EN
   logic             abort;
`endif

   int errors   = 0;
   int checks   = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .clear   (clear),
      .start   (start),
      .op      (op),
      .amount  (amount),
      .data_in (data_in),
      .sr_q    (sr_q),
`ifdef SHIFT_SEQ_ABORT_EN
      .abort   (abort),
`endif
      .sr_s    (sr_s),
      .sr_msb  (sr_msb),
      .sr_lsb  (sr_lsb),
      .sr_i    (sr_i),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   // 4-bit universal shift register driven by the controller
   always @(posedge clk or negedge clear) begin
      if (!clear) begin
         sr_q <= '0;
      end else begin
         case (sr_s)
            2'b01:   sr_q <= {sr_msb, sr_q[WIDTH-1:1]};
            2'b10:   sr_q <= {sr_q[WIDTH-2:0], sr_lsb};
            2'b11:   sr_q <= sr_i;
            default: sr_q <= sr_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Expected-behaviour model
   // ------------------------------------------------------------------
   typedef struct {
      logic [1:0] s;
      logic       msb;
      logic       lsb;
      logic       busy;
      logic       done;
      logic       err;
      logic [3:0] q;
      logic [3:0] i;
   } exp_t;

   exp_t       tl[$];          // expected outputs, one entry per upcoming cycle
   logic [3:0] m_q = 4'd0;     // register value once the timeline drains
   logic [3:0] m_i = 4'd0;     // latched parallel data

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t idle_rec(input logic [3:0] q);
      exp_t e;
      e.s = 2'b00; e.msb = 1'b0; e.lsb = 1'b0;
      e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0;
      e.q = q; e.i = m_i;
      return e;
   endfunction

   // Value of v after k steps of the given shift/rotate op
   function automatic logic [3:0] apply(input logic [2:0] o, input logic [3:0] v, input int k);
      logic [7:0]        t;
      logic signed [3:0] sv;
      logic [3:0]        r;
      r = v;
      case (o)
         3'd1: r = v >> k;
         3'd2: r = v << k;
         3'd3: begin t = {v, v} >> (k % 4); r = t[3:0]; end
         3'd4: begin t = {v, v} << (k % 4); r = t[7:4]; end
         3'd5: begin sv = v; r = sv >>> k; end
         default: r = v;
      endcase
      return r;
   endfunction

   task automatic push_cmd(input logic [2:0] o, input int amt, input logic [3:0] data, input int abort_at);
      exp_t       e;
      logic [3:0] v;
      logic [3:0] w;
      int         n;
      v   = m_q;
      m_i = data;
      if (o == 3'd0) begin
         e = idle_rec(v); e.s = 2'b11; e.busy = 1'b1; tl.push_back(e);
         v = data;
         e = idle_rec(v); e.done = 1'b1; tl.push_back(e);
      end else if (o > 3'd5) begin
         e = idle_rec(v); e.err = 1'b1; tl.push_back(e);
      end else begin
         n = (abort_at >= 0 && abort_at < amt) ? abort_at : amt;
         for (int k = 0; k < n; k++) begin
            w = apply(o, v, k);
            e = idle_rec(w);
            e.busy = 1'b1;
            e.s    = (o == 3'd2 || o == 3'd4) ? 2'b10 : 2'b01;
            e.msb  = (o == 3'd3) ? w[0] : (o == 3'd5) ? w[3] : 1'b0;
            e.lsb  = (o == 3'd4) ? w[3] : 1'b0;
            tl.push_back(e);
         end
         v = apply(o, v, n);
         if (n < amt) begin
            e = idle_rec(v); e.busy = 1'b1; tl.push_back(e);
         end
         e = idle_rec(v); e.done = 1'b1; tl.push_back(e);
      end
      m_q = v;
   endtask

   // Single compare process, every cycle
   always @(negedge clk) begin
      exp_t e;
      if (!clear) begin
         tl.delete();
         m_q = 4'd0;
         m_i = 4'd0;
         e = idle_rec(4'd0);
      end else if (tl.size() != 0) begin
         e = tl.pop_front();
      end else begin
         e = idle_rec(m_q);
      end
      check("sr_s",   {6'd0, sr_s},  {6'd0, e.s});
      check("sr_msb", {7'd0, sr_msb}, {7'd0, e.msb});
      check("sr_lsb", {7'd0, sr_lsb}, {7'd0, e.lsb});
      check("busy",   {7'd0, busy},   {7'd0, e.busy});
      check("done",   {7'd0, done},   {7'd0, e.done});
      check("err",    {7'd0, err},    {7'd0, e.err});
      check("sr_i",   {4'd0, sr_i},   {4'd0, e.i});
      check("sr_q",   {4'd0, sr_q},   {4'd0, e.q});
      if (done) done_cnt++;
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic wait_done();
      for (int c = 0; c < 40; c++) begin
         if (tl.size() == 0) break;
         @(posedge clk);
      end
      check("timeline_drained", {7'd0, tl.size() == 0}, 8'd1);
      tl.delete();
   endtask

   task automatic issue(input logic [2:0] o, input int amt, input logic [3:0] data,
                        input bit hold, input int abort_at, input int clear_at);
      @(posedge clk); #2;
      start   = 1'b1;
      op      = o;
      amount  = CNT_W'(amt);
      data_in = data;
      @(posedge clk); #2;
      if (!hold) start = 1'b0;
      push_cmd(o, amt, data, abort_at);
      if (hold) begin
         // keep start high until the DONE cycle, then drop it before IDLE
         repeat (amt) @(posedge clk);
         #2 start = 1'b0;
      end
`ifdef SHIFT_SEQ_ABORT_EN
      if (abort_at >= 0) begin
         repeat (abort_at) @(posedge clk);
         #2 abort = 1'b1;
         @(posedge clk);
         #2 abort = 1'b0;
      end
`endif
      if (clear_at >= 0) begin
         repeat (clear_at) @(posedge clk);
         #1 clear = 1'b0;
         @(posedge clk);
         #1 clear = 1'b1;
      end
      wait_done();
      #1;
   endtask

   initial begin
      clear   = 1'b0;
      start   = 1'b0;
      op      = 3'd0;
      amount  = '0;
      data_in = '0;
`ifdef SHIFT_SEQ_ABORT_EN
      abort   = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #2 clear = 1'b1;

      // Load 1011
      issue(3'd0, 0, 4'b1011, 1'b0, -1, -1);
      check("load_q", {4'd0, sr_q}, 8'b1011);
      check("load_done_cnt", done_cnt[7:0], 8'd1);

      // SHR by 2: 1011 -> 0010
      issue(3'd1, 2, 4'b0110, 1'b0, -1, -1);
      check("shr_q", {4'd0, sr_q}, 8'b0010);
      check("shr_model_q", {4'd0, m_q}, 8'b0010);
      check("shr_done_cnt", done_cnt[7:0], 8'd2);

      // ROL by 4 restores 1001
      issue(3'd0, 0, 4'b1001, 1'b0, -1, -1);
      issue(3'd4, 4, 4'b0101, 1'b0, -1, -1);
      check("rol4_q", {4'd0, sr_q}, 8'b1001);

      // ASR by 3: 1000 -> 1111, then SHR by 0 leaves it
      issue(3'd0, 0, 4'b1000, 1'b0, -1, -1);
      issue(3'd5, 3, 4'b0011, 1'b0, -1, -1);
      check("asr_q", {4'd0, sr_q}, 8'b1111);
      issue(3'd1, 0, 4'b1010, 1'b0, -1, -1);
      check("shr0_q", {4'd0, sr_q}, 8'b1111);
      check("shr0_done_cnt", done_cnt[7:0], 8'd7);

      // Illegal op: err only, no done
      issue(3'd6, 3, 4'b1100, 1'b0, -1, -1);
      check("illegal_done_cnt", done_cnt[7:0], 8'd7);

      // SHL by 5 on 0001 with start held: single command, all zeros
      issue(3'd0, 0, 4'b0001, 1'b0, -1, -1);
      issue(3'd2, 5, 4'b0111, 1'b1, -1, -1);
      check("shl5_q", {4'd0, sr_q}, 8'b0000);
      check("shl5_done_cnt", done_cnt[7:0], 8'd9);

      // ROR by 6 on 0110 cut short by clear after 2 shifts
      issue(3'd0, 0, 4'b0110, 1'b0, -1, -1);
      issue(3'd3, 6, 4'b1110, 1'b0, -1, 2);
      check("clear_q", {4'd0, sr_q}, 8'b0000);
      check("clear_done_cnt", done_cnt[7:0], 8'd10);

      // ROR by 5 wraps to a rotate by 1: 0110 -> 0011
      issue(3'd0, 0, 4'b0110, 1'b0, -1, -1);
      issue(3'd3, 5, 4'b0000, 1'b0, -1, -1);
      check("ror5_q", {4'd0, sr_q}, 8'b0011);
      check("ror5_model_q", {4'd0, m_q}, 8'b0011);

`ifdef SHIFT_SEQ_ABORT_EN
      // SHR by 3 on 1000 aborted after one shift -> 0100
      issue(3'd0, 0, 4'b1000, 1'b0, -1, -1);
      issue(3'd1, 3, 4'b0000, 1'b0, 1, -1);
      check("abort_q", {4'd0, sr_q}, 8'b0100);
      check("abort_done_cnt", done_cnt[7:0], 8'd14);
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
